// File: rtl/async_mem_seq_if.sv
// CPU-side bus of the asynchronous memory sequencer: request, captured
// address/data and the completion handshake.
interface async_mem_seq_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, busy
    );
endinterface

// File: rtl/async_mem_seq.sv
// Bus-cycle sequencer that turns a CPU request into a timed select pulse
// on a boot ROM window or a RAM window, then returns read data with ack.
module async_mem_seq #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter logic [15:0] ROM_BASE      = 16'hFF00,
    parameter logic [15:0] RAM_BASE      = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    async_mem_seq_if.slave        cpu,
    output logic                  rom_sel_o,
    output logic [7:0]            rom_a_o,
    input  logic [7:0]            rom_dout_i,
    output logic                  ram_sel_o,
    output logic                  ram_we_o,
    output logic [9:0]            ram_a_o,
    output logic [7:0]            ram_din_o,
    input  logic [7:0]            ram_dout_i
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_e;

    localparam logic [3:0] COUNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        romHit;
    logic        ramHit;
    logic        inAccess;

    // ROM wins when both windows overlap, so RAM hit is masked by ROM hit.
    assign romHit   = (addr_q[15:8] == ROM_BASE[15:8]);
    assign ramHit   = !romHit && (addr_q[15:10] == RAM_BASE[15:10]);
    assign inAccess = (state_q == ACCESS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            addr_q  <= 16'd0;
            we_q    <= 1'b0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu.req) begin
                    addr_d  = cpu.addr;
                    we_d    = cpu.we;
                    wdata_d = cpu.wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                count_d = COUNT_LOAD;
                state_d = ACCESS;
            end
            ACCESS: begin
                // Data is sampled on the last select cycle; writes leave rdata alone.
                if (count_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (romHit) begin
                            rdata_d = rom_dout_i;
                        end else if (ramHit) begin
                            rdata_d = ram_dout_i;
                        end else begin
                            rdata_d = 8'hFF;
                        end
                    end
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ROM is read-only: a write into its window raises no select at all.
    assign rom_sel_o = inAccess && romHit && !we_q;
    assign ram_sel_o = inAccess && ramHit;
    assign ram_we_o  = ram_sel_o && we_q;
    assign rom_a_o   = addr_q[7:0];
    assign ram_a_o   = addr_q[9:0];
    assign ram_din_o = wdata_q;

    assign cpu.rdata = rdata_q;
    assign cpu.ack   = (state_q == DONE);
    assign cpu.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_async_mem_seq.sv
// Scoreboard bench for async_mem_seq: directed cycles push expectations,
// a negedge monitor pops and compares them whenever ack is seen.
module tb_async_mem_seq;

    localparam int N = 2;

    typedef struct packed {
        logic [7:0] rdata;
        logic [7:0] romSel;
        logic [7:0] ramSel;
        logic [7:0] ramWe;
        logic [9:0] expA;
        logic [7:0] din;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    exp_t sb[$];

    async_mem_seq_if cpu ();
    async_mem_seq_if cpu1 ();
    async_mem_seq_if cpu15 ();

    logic       romSel, ramSel, ramWe;
    logic [7:0] romA, ramDin, romDout, ramDout;
    logic [9:0] ramA;
    logic [7:0] ramMem [1024];

    logic        xReq, xWe;
    logic [15:0] xAddr;
    logic [7:0]  xWdata;
    logic        romSel1, ramSel1, ramWe1, romSel15, ramSel15, ramWe15;
    logic [7:0]  romA1, ramDin1, romA15, ramDin15;
    logic [9:0]  ramA1, ramA15;

    function automatic logic [7:0] romModel(input logic [7:0] a);
        case (a)
            8'hFE:   romModel = 8'hFF;
            8'h00:   romModel = 8'h4F;
            8'h01:   romModel = 8'h4C;
            default: romModel = a ^ 8'h5A;
        endcase
    endfunction

    function automatic exp_t mkExp(input logic [7:0] r, input logic [7:0] rs,
                                   input logic [7:0] ms, input logic [7:0] mw,
                                   input logic [9:0] a, input logic [7:0] d);
        exp_t e;
        e.rdata  = r;
        e.romSel = rs;
        e.ramSel = ms;
        e.ramWe  = mw;
        e.expA   = a;
        e.din    = d;
        return e;
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign romDout = romModel(romA);
    assign ramDout = ramMem[ramA];

    always @(posedge clk) begin
        if (ramWe) ramMem[ramA] <= ramDin;
    end

    async_mem_seq #(.ACCESS_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .cpu(cpu),
        .rom_sel_o(romSel), .rom_a_o(romA), .rom_dout_i(romDout),
        .ram_sel_o(ramSel), .ram_we_o(ramWe), .ram_a_o(ramA),
        .ram_din_o(ramDin), .ram_dout_i(ramDout)
    );

    assign cpu1.req    = xReq;
    assign cpu1.we     = xWe;
    assign cpu1.addr   = xAddr;
    assign cpu1.wdata  = xWdata;
    assign cpu15.req   = xReq;
    assign cpu15.we    = xWe;
    assign cpu15.addr  = xAddr;
    assign cpu15.wdata = xWdata;

    async_mem_seq #(.ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .cpu(cpu1),
        .rom_sel_o(romSel1), .rom_a_o(romA1), .rom_dout_i(romModel(romA1)),
        .ram_sel_o(ramSel1), .ram_we_o(ramWe1), .ram_a_o(ramA1),
        .ram_din_o(ramDin1), .ram_dout_i(8'h00)
    );

    async_mem_seq #(.ACCESS_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst), .cpu(cpu15),
        .rom_sel_o(romSel15), .rom_a_o(romA15), .rom_dout_i(romModel(romA15)),
        .ram_sel_o(ramSel15), .ram_we_o(ramWe15), .ram_a_o(ramA15),
        .ram_din_o(ramDin15), .ram_dout_i(8'h00)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: per-transaction select/strobe widths and latency, scored on ack.
    int   lat = 0, romCnt = 0, ramCnt = 0, weCnt = 0;
    logic prevBusy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (cpu.busy && !prevBusy) begin
            lat = 0; romCnt = 0; ramCnt = 0; weCnt = 0;
        end else if (cpu.busy) begin
            lat++;
        end
        if (romSel) romCnt++;
        if (ramSel) ramCnt++;
        if (ramWe)  weCnt++;
        if (ramWe && sb.size() > 0) begin
            checkOutput("ramAddr", 32'(ramA), 32'(sb[0].expA));
            checkOutput("ramDin", 32'(ramDin), 32'(sb[0].din));
        end
        if (romSel && sb.size() > 0) begin
            checkOutput("romAddr", 32'(romA), 32'(sb[0].expA[7:0]));
        end
        if (cpu.ack) begin
            if (sb.size() == 0) begin
                checkOutput("unexpectedAck", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                checkOutput("rdata", 32'(cpu.rdata), 32'(e.rdata));
                checkOutput("romSelWidth", romCnt, 32'(e.romSel));
                checkOutput("ramSelWidth", ramCnt, 32'(e.ramSel));
                checkOutput("ramWeWidth", weCnt, 32'(e.ramWe));
                checkOutput("ackLatency", lat, N + 1);
            end
        end
        prevBusy = cpu.busy;
    end

    task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [7:0] d, input exp_t e);
        logic got;
        sb.push_back(e);
        @(negedge clk);
        cpu.req = 1'b1; cpu.we = w; cpu.addr = a; cpu.wdata = d;
        @(posedge clk); #1;
        checkOutput("accept", 32'(cpu.busy), 32'd1);
        @(negedge clk);
        cpu.req = 1'b0; cpu.we = ~w; cpu.addr = ~a; cpu.wdata = ~d;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu.ack) begin got = 1'b1; break; end
        end
        checkOutput("ackSeen", 32'(got), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic got;
        int   lastCyc, sel1, sel15, ack1Edge, ack15Edge;

        foreach (ramMem[i]) ramMem[i] = 8'h00;
        cpu.req = 1'b0; cpu.we = 1'b0; cpu.addr = 16'h0; cpu.wdata = 8'h0;
        xReq = 1'b0; xWe = 1'b0; xAddr = 16'h0; xWdata = 8'h0;

        #12;
        checkOutput("resetCtrl", 32'({cpu.ack, cpu.busy, romSel, ramSel, ramWe, cpu.rdata}), 32'd0);
        checkOutput("resetAddr", 32'({romA, ramA, ramDin}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 16'hFFFE, 8'h00, mkExp(8'hFF, 2, 0, 0, 10'h0FE, 8'h00));
        applyStimulus(1'b1, 16'h0123, 8'hA5, mkExp(8'hFF, 0, 2, 2, 10'h123, 8'hA5));
        applyStimulus(1'b0, 16'h0123, 8'h00, mkExp(8'hA5, 0, 2, 0, 10'h123, 8'h00));
        applyStimulus(1'b0, 16'h8000, 8'h00, mkExp(8'hFF, 0, 0, 0, 10'h000, 8'h00));
        applyStimulus(1'b1, 16'h03FF, 8'h5C, mkExp(8'hFF, 0, 2, 2, 10'h3FF, 8'h5C));
        applyStimulus(1'b0, 16'h03FF, 8'h00, mkExp(8'h5C, 0, 2, 0, 10'h3FF, 8'h00));
        applyStimulus(1'b1, 16'hFF00, 8'h77, mkExp(8'h5C, 0, 0, 0, 10'h000, 8'h00));
        applyStimulus(1'b0, 16'hFFFF, 8'h00, mkExp(8'hA5, 2, 0, 0, 10'h0FF, 8'h00));
        applyStimulus(1'b0, 16'h0400, 8'h00, mkExp(8'hFF, 0, 0, 0, 10'h000, 8'h00));

        // Back-to-back with req held high and addr scrambled while busy.
        for (int k = 0; k < 4; k++) begin
            sb.push_back(mkExp((k % 2 == 0) ? 8'h4F : 8'h4C, 2, 0, 0,
                               (k % 2 == 0) ? 10'h000 : 10'h001, 8'h00));
        end
        @(negedge clk);
        cpu.req = 1'b1; cpu.we = 1'b0; cpu.addr = 16'hFF00; cpu.wdata = 8'h00;
        lastCyc = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (cpu.busy) begin got = 1'b1; break; end
            end
            checkOutput("b2bAccept", 32'(got), 32'd1);
            if (k > 0) checkOutput("b2bSpacing", 32'(cyc - lastCyc), N + 3);
            lastCyc = cyc;
            @(negedge clk);
            cpu.addr = 16'h1234; cpu.we = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (cpu.ack) begin got = 1'b1; break; end
            end
            checkOutput("b2bAck", 32'(got), 32'd1);
            cpu.addr = (k % 2 == 0) ? 16'hFF01 : 16'hFF00;
            cpu.we = 1'b0;
        end
        cpu.req = 1'b0;

        // Reset pulse in the middle of a RAM write.
        @(negedge clk);
        cpu.req = 1'b1; cpu.we = 1'b1; cpu.addr = 16'h0200; cpu.wdata = 8'h3C;
        @(posedge clk); #1;
        @(negedge clk);
        cpu.req = 1'b0;
        @(posedge clk); #2;
        checkOutput("rstPreWe", 32'(ramWe), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstAbortCtrl", 32'({cpu.ack, cpu.busy, romSel, ramSel, ramWe, cpu.rdata}), 32'd0);
        checkOutput("rstAbortAddr", 32'({romA, ramA, ramDin}), 32'd0);
        @(posedge clk); #1;
        checkOutput("rstHeld", 32'({cpu.ack, cpu.busy, ramSel, ramWe}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0123, 8'h00, mkExp(8'hA5, 0, 2, 0, 10'h123, 8'h00));

        // ACCESS_CYCLES=1 and 15 builds driven together.
        @(negedge clk);
        xReq = 1'b1; xWe = 1'b0; xAddr = 16'hFFFE;
        @(posedge clk); #1;
        checkOutput("xAccept", 32'({cpu1.busy, cpu15.busy}), 32'd3);
        @(negedge clk);
        xReq = 1'b0;
        sel1 = 0; sel15 = 0; ack1Edge = -1; ack15Edge = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (romSel1) sel1++;
            if (romSel15) sel15++;
            if (cpu1.ack && ack1Edge < 0) ack1Edge = e;
            if (cpu15.ack && ack15Edge < 0) ack15Edge = e;
        end
        checkOutput("ac1SelWidth", 32'(sel1), 32'd1);
        checkOutput("ac15SelWidth", 32'(sel15), 32'd15);
        checkOutput("ac1AckEdge", 32'(ack1Edge), 32'd2);
        checkOutput("ac15AckEdge", 32'(ack15Edge), 32'd16);
        checkOutput("ac1Rdata", 32'(cpu1.rdata), 32'hFF);
        checkOutput("ac15Rdata", 32'(cpu15.rdata), 32'hFF);

        repeat (3) @(negedge clk);
        checkOutput("sbEmpty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/async_mem_seq.md
ASYNC_MEM_SEQ -- requirements
Module: async_mem_seq

Interface
REQ-001 The block SHALL have parameter ACCESS_CYCLES, default 2: the number of clock cycles the memory select is held before data is sampled; legal range 1..15.
REQ-002 The block SHALL have parameter ROM_BASE, default 16'hFF00: base address of the 256-byte boot ROM window.
REQ-003 The block SHALL have parameter RAM_BASE, default 16'h0000: base address of the 1 KiB RAM window.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: `clk` (input, 1, rising-edge clock) and `rst` (input, 1, async active-high reset).
REQ-005 The CPU side SHALL have these ports:
- `req` (input, 1): bus-cycle request.
- `we` (input, 1): 1 = write.
- `addr` (input, 16): CPU address.
- `wdata` (input, 8): write data.
- `rdata` (output, 8): read data.
- `ack` (output, 1): cycle complete.
- `busy` (output, 1): cycle in progress.
REQ-006 The ROM side SHALL have these ports:
- `rom_sel` (output, 1): ROM select.
- `rom_a` (output, 8): ROM address.
- `rom_dout` (input, 8): combinational ROM data.
REQ-007 The RAM side SHALL have these ports:
- `ram_sel` (output, 1): RAM select.
- `ram_we` (output, 1): RAM write strobe.
- `ram_a` (output, 10): RAM address.
- `ram_din` (output, 8): RAM write data.
- `ram_dout` (input, 8): RAM read data.

Function
REQ-008 The block SHALL implement the states IDLE, SETUP, ACCESS and DONE.
REQ-009 In IDLE, `req`=1 at a rising edge SHALL capture `addr`, `we` and `wdata` into internal registers and move the block to SETUP.
REQ-010 `req` SHALL be ignored in every state other than IDLE; changes to `addr`, `we` or `wdata` after capture SHALL have no effect on the cycle in progress.
REQ-011 Decode SHALL use the captured address:
- ROM hit: addr[15:8] == ROM_BASE[15:8].
- RAM hit: addr[15:10] == RAM_BASE[15:10].
- Otherwise unmapped.
- If both windows match, ROM SHALL take priority.
REQ-012 From SETUP the block SHALL move to ACCESS after exactly one cycle; address outputs (`rom_a` = addr[7:0], `ram_a` = addr[9:0]) and `ram_din` SHALL be driven from SETUP onward and held stable through DONE.
REQ-013 In ACCESS, the select of the hit region (`rom_sel` or `ram_sel`) SHALL be 1 for exactly ACCESS_CYCLES cycles, counted by a 4-bit down-counter loaded with ACCESS_CYCLES-1 on entry to ACCESS.
REQ-014 `ram_we` SHALL equal `ram_sel` AND captured `we` during ACCESS, and SHALL be 0 otherwise.
REQ-015 A write to the ROM window or to an unmapped address SHALL assert no select and no write strobe, SHALL still take the full ACCESS duration, and SHALL complete with `ack`.
REQ-016 On the edge where the counter reaches 0 in ACCESS, the block SHALL move to DONE and register `rdata`:
- ROM read: `rom_dout`.
- RAM read: `ram_dout`.
- Unmapped read: 8'hFF.
- Any write: `rdata` unchanged.
REQ-017 Selects SHALL deassert on entry to DONE.
REQ-018 `ack` SHALL be 1 for exactly the one cycle spent in DONE; DONE SHALL return to IDLE unconditionally.
REQ-019 Read latency SHALL be: `ack` and valid `rdata` visible after the (ACCESS_CYCLES+1)th rising edge following the accepting edge.
REQ-020 `rdata` SHALL hold its value until the next completed read.
REQ-021 `busy` SHALL be 1 in SETUP, ACCESS and DONE, and 0 in IDLE.
REQ-022 If `req` is still 1 in the IDLE cycle after DONE, a new cycle SHALL be accepted (back-to-back); minimum request-to-request spacing SHALL be ACCESS_CYCLES+3 cycles.
REQ-023 Address arithmetic SHALL use no wrap or carry beyond the window bits; addresses FFFF and 0x03FF SHALL map to `rom_a`=8'hFF and `ram_a`=10'h3FF respectively.

Reset
REQ-024 While `rst`=1, regardless of `clk`:
- state SHALL be IDLE.
- `ack`, `busy`, `rom_sel`, `ram_sel`, `ram_we` SHALL be 0.
- `rdata`, `rom_a`, `ram_a`, `ram_din` SHALL be 0.
- the counter SHALL be 0.
REQ-025 Reset asserted mid-cycle SHALL abort the cycle immediately, with no `ack` and no further `ram_we`; after `rst` deasserts, the first `req` SHALL be accepted on the first rising edge.

Verification
REQ-026 ROM read, ACCESS_CYCLES=2, `addr`=16'hFFFE, ROM model returning 8'hFF at 8'hFE -> `rom_sel` high 2 cycles, `ack` high 1 cycle 3 edges after acceptance, `rdata`=8'hFF.
REQ-027 RAM write 8'hA5 to 16'h0123, then RAM read of 16'h0123 -> `ram_we` high exactly 2 cycles with `ram_a`=10'h123 and `ram_din`=8'hA5; the read returns `rdata`=8'hA5.
REQ-028 Unmapped read at 16'h8000 -> no select asserted, `ack` after 3 edges, `rdata`=8'hFF; ROM write at 16'hFF00 -> no select, `ack` received, `rdata` unchanged.
REQ-029 `req` held high continuously, alternating ROM addresses FF00/FF01 with model data 8'h4F/8'h4C -> accepts every 5 cycles, `rdata` sequence 8'h4F, 8'h4C; `addr` changes during `busy` are ignored.
REQ-030 `rst` pulsed during ACCESS of a RAM write -> `ram_we` and `ram_sel` drop asynchronously, no `ack`, all outputs 0; the next read after release completes normally.
REQ-031 ACCESS_CYCLES=1 and ACCESS_CYCLES=15 builds -> select width 1 and 15 cycles respectively; `ack` 2 and 16 edges after acceptance.
